// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter
// Shares the LC-3 single-port main memory between the CPU MAR/MDR path and
// the loader/debug special port. One access at a time, round-robin on ties.
// The granted address, write data and write enable are registered and held
// for MEM_LAT cycles, then the owner gets a one-cycle acknowledge.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata         CPU completion pulse and read data
//   spc_req/we/addr/wdata      special-port request, held until spc_ack
//   spc_ack, spc_rdata         special-port completion pulse and read data
//   mem_addr/wdata/we          registered memory controls
//   mem_rdata                  memory read data
//   busy                       high while an access is in flight (ACCESS, DONE)
//   owner                      current/last grantee (0 = CPU, 1 = special port)
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here
// ACCESS | memory controls held stable for MEM_LAT cycles
// DONE   | one-cycle ack to the owner
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              spc_req,
  input  logic              spc_we,
  input  logic [ADDR_W-1:0] spc_addr,
  input  logic [DATA_W-1:0] spc_wdata,
  output logic              spc_ack,
  output logic [DATA_W-1:0] spc_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       we_q;
  logic       last_owner;
  logic       grant_any;
  logic       grant_spc;

  // On a tie the special port wins only when the CPU was served last.
  assign grant_any = cpu_req | spc_req;
  assign grant_spc = spc_req & (~cpu_req | ~last_owner);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy    = (state == ACCESS) || (state == DONE);
    cpu_ack = (state == DONE) && !owner;
    spc_ack = (state == DONE) && owner;
  end

  // Datapath: grant latch, latency counter, read-data capture.
  // mem_we is cleared every cycle and only set on the grant edge of a write,
  // so it is high for exactly the first ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cpu_rdata  <= '0;
      spc_rdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_addr   <= grant_spc ? spc_addr  : cpu_addr;
            mem_wdata  <= grant_spc ? spc_wdata : cpu_wdata;
            we_q       <= grant_spc ? spc_we    : cpu_we;
            mem_we     <= grant_spc ? spc_we    : cpu_we;
            owner      <= grant_spc;
            last_owner <= grant_spc;
            cnt        <= CNT_INIT;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            if (owner) spc_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: a MEM_LAT=1 instance driven by
// directed table rows, a contention sequence, reset cases and a randomized
// run checked against a transaction-level model; a MEM_LAT=3 instance covers
// the longer latency.
module tb_lc3_mem_arbiter;

  logic        clk;
  logic        reset;

  // MEM_LAT = 1 instance
  logic        cpu_req, cpu_we, spc_req, spc_we;
  logic [15:0] cpu_addr, cpu_wdata, spc_addr, spc_wdata;
  logic        cpu_ack, spc_ack, mem_we, busy, owner;
  logic [15:0] cpu_rdata, spc_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] mem1 [65536];

  // MEM_LAT = 3 instance (CPU side only)
  logic        c3_req, c3_we;
  logic [15:0] c3_addr, c3_wdata;
  logic        c3_ack, s3_ack, m3_we, busy3, owner3;
  logic [15:0] c3_rdata, s3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic [15:0] mem3 [65536];

  // Reference memory, updated only from the bench's own expectations
  logic [15:0] ref_mem [65536];
  logic [15:0] exp_cpu_rd, exp_spc_rd;

  int checks = 0;
  int errors = 0;

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .spc_req(spc_req), .spc_we(spc_we), .spc_addr(spc_addr), .spc_wdata(spc_wdata),
    .spc_ack(spc_ack), .spc_rdata(spc_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
    .spc_req(1'b0), .spc_we(1'b0), .spc_addr(16'h0000), .spc_wdata(16'h0000),
    .spc_ack(s3_ack), .spc_rdata(s3_rdata),
    .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_we(m3_we), .mem_rdata(m3_rdata),
    .busy(busy3), .owner(owner3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory models: combinational read, write on the clock edge
  assign mem_rdata = mem1[mem_addr];
  assign m3_rdata  = mem3[m3_addr];

  initial begin
    for (int a = 0; a < 65536; a++) mem1[a] = 16'(a) ^ 16'h5A5A;
    mem1[16'h3000] = 16'h1234;
    forever begin
      @(posedge clk);
      if (mem_we) mem1[mem_addr] <= mem_wdata;
    end
  end

  initial begin
    for (int a = 0; a < 65536; a++) mem3[a] = 16'h0000;
    mem3[16'h4000] = 16'hCAFE;
    forever begin
      @(posedge clk);
      if (m3_we) mem3[m3_addr] <= m3_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        who;   // 0 = CPU, 1 = special port
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  // One isolated transaction on the MEM_LAT=1 instance, starting in IDLE.
  task automatic run1(input vec_t v);
    if (v.who) begin
      spc_req = 1'b1; spc_we = v.we; spc_addr = v.addr; spc_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    step();
    chk1("t_busy1", busy, 1'b1);
    chk1("t_owner", owner, v.who);
    chk16("t_addr", mem_addr, v.addr);
    chk1("t_we1", mem_we, v.we);
    if (v.we) chk16("t_wdata", mem_wdata, v.wdata);
    chk1("t_noack1", cpu_ack | spc_ack, 1'b0);
    step();
    chk1("t_cpu_ack", cpu_ack, ~v.who);
    chk1("t_spc_ack", spc_ack, v.who);
    chk1("t_we2", mem_we, 1'b0);
    chk16("t_addr2", mem_addr, v.addr);
    if (v.we) ref_mem[v.addr] = v.wdata;
    else if (v.who) exp_spc_rd = v.exp_rd;
    else exp_cpu_rd = v.exp_rd;
    chk16("t_cpu_rd", cpu_rdata, exp_cpu_rd);
    chk16("t_spc_rd", spc_rdata, exp_spc_rd);
    cpu_req = 1'b0;
    spc_req = 1'b0;
    step();
    chk1("t_busy3", busy, 1'b0);
    chk1("t_noack3", cpu_ack | spc_ack, 1'b0);
  endtask

  // One CPU transaction on the MEM_LAT=3 instance.
  task automatic run3(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                      input logic [15:0] exp_rd);
    c3_req = 1'b1; c3_we = we; c3_addr = addr; c3_wdata = wd;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k <= 3) begin
        chk1("l3_busy", busy3, 1'b1);
        chk16("l3_addr", m3_addr, addr);
        chk1("l3_we", m3_we, we && (k == 1));
        chk1("l3_noack", c3_ack, 1'b0);
      end else if (k == 4) begin
        chk1("l3_ack", c3_ack, 1'b1);
        chk1("l3_spc_ack", s3_ack, 1'b0);
        chk16("l3_rdata", c3_rdata, exp_rd);
        c3_req = 1'b0;
      end else begin
        chk1("l3_idle", busy3, 1'b0);
        chk1("l3_ack_done", c3_ack, 1'b0);
      end
    end
  endtask

  vec_t vecs [7];

  initial begin
    int w, ncpu, nspc, g, ma;
    logic mo, mlast, mwe, sel, exp_cack, exp_sack, exp_busy;
    logic [15:0] maddr, mwd, mpend;

    vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    vecs[1] = '{1'b1, 1'b1, 16'h3005, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h3005, 16'h0000, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'h3005, 16'h0000, 16'hBEEF};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0001, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0001};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};

    for (int a = 0; a < 65536; a++) ref_mem[a] = 16'(a) ^ 16'h5A5A;
    ref_mem[16'h3000] = 16'h1234;

    c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;

    // Reset with both requests high
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h1111;
    spc_req = 1'b1; spc_we = 1'b1; spc_addr = 16'h0020; spc_wdata = 16'h2222;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cpu_ack", cpu_ack, 1'b0);
    chk1("rst_spc_ack", spc_ack, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_owner", owner, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk16("rst_cpu_rd", cpu_rdata, 16'h0000);
    chk16("rst_spc_rd", spc_rdata, 16'h0000);
    chk1("rst_busy3", busy3, 1'b0);
    reset = 1'b1;
    step();
    chk1("first_owner", owner, 1'b0);
    chk1("first_busy", busy, 1'b1);
    chk16("first_addr", mem_addr, 16'h0010);
    chk1("first_we", mem_we, 1'b0);
    // Requests drop mid-access; the CPU access must still complete.
    cpu_req = 1'b0;
    spc_req = 1'b0;
    step();
    chk1("first_cpu_ack", cpu_ack, 1'b1);
    chk1("first_spc_ack", spc_ack, 1'b0);
    exp_cpu_rd = ref_mem[16'h0010];
    exp_spc_rd = 16'h0000;
    chk16("first_cpu_rd", cpu_rdata, exp_cpu_rd);
    step();
    chk1("first_idle", busy, 1'b0);
    chk1("first_ack_gone", cpu_ack | spc_ack, 1'b0);

    // MEM_LAT = 3: read then write
    run3(1'b0, 16'h4000, 16'h0000, 16'hCAFE);
    run3(1'b1, 16'h4001, 16'h55AA, 16'hCAFE);
    chk16("l3_mem_written", mem3[16'h4001], 16'h55AA);

    // Directed table
    for (int i = 0; i < 7; i++) run1(vecs[i]);

    // Contention: both held through three accesses each; CPU first.
    ncpu = 0; nspc = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    spc_req = 1'b1; spc_we = 1'b0; spc_addr = 16'h0200;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (!(cpu_ack || spc_ack) && w < 10);
      if (!(cpu_ack || spc_ack)) begin
        chk1("cont_ack_seen", 1'b0, 1'b1);
        break;
      end
      chk1("cont_order", spc_ack, 1'(k & 1));
      chk1("cont_owner", owner, 1'(k & 1));
      chk16("cont_spacing", 16'(w), (k == 0) ? 16'd2 : 16'd3);
      if (k & 1) begin
        exp_spc_rd = ref_mem[spc_addr];
        chk16("cont_spc_rd", spc_rdata, exp_spc_rd);
        nspc++;
        if (nspc == 3) spc_req = 1'b0;
        else spc_addr = spc_addr + 16'd1;
      end else begin
        exp_cpu_rd = ref_mem[cpu_addr];
        chk16("cont_cpu_rd", cpu_rdata, exp_cpu_rd);
        ncpu++;
        if (ncpu == 3) cpu_req = 1'b0;
        else cpu_addr = cpu_addr + 16'd1;
      end
    end
    cpu_req = 1'b0;
    spc_req = 1'b0;
    step();

    // Randomized traffic against a transaction-level model.
    // A grant in the IDLE cycle c puts the ack at c+2 and frees the
    // arbiter for a new grant at c+3.
    g = -10; ma = -10; mo = 1'b1; mlast = 1'b1; mwe = 1'b0;
    maddr = '0; mwd = '0; mpend = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == ma && !mwe) begin
        if (mo) exp_spc_rd = mpend;
        else exp_cpu_rd = mpend;
      end
      exp_busy = (c > g) && (c <= ma);
      exp_cack = (c == ma) && !mo;
      exp_sack = (c == ma) && mo;
      chk1("r_busy", busy, exp_busy);
      chk1("r_cpu_ack", cpu_ack, exp_cack);
      chk1("r_spc_ack", spc_ack, exp_sack);
      chk1("r_mem_we", mem_we, (c == g + 1) && mwe);
      chk1("r_owner", owner, mo);
      chk16("r_cpu_rd", cpu_rdata, exp_cpu_rd);
      chk16("r_spc_rd", spc_rdata, exp_spc_rd);
      if (exp_busy) begin
        chk16("r_mem_addr", mem_addr, maddr);
        chk16("r_mem_wdata", mem_wdata, mwd);
      end
      if (!cpu_req || exp_cack) begin
        cpu_req = 1'($urandom_range(0, 1));
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 16'($urandom_range(0, 15));
        cpu_wdata = 16'($urandom);
      end
      if (!spc_req || exp_sack) begin
        spc_req = 1'($urandom_range(0, 1));
        spc_we = 1'($urandom_range(0, 1));
        spc_addr = 16'($urandom_range(0, 15));
        spc_wdata = 16'($urandom);
      end
      if (c > ma && (cpu_req || spc_req)) begin
        sel = spc_req && (!cpu_req || !mlast);
        g = c;
        ma = c + 2;
        mo = sel;
        mlast = sel;
        mwe = sel ? spc_we : cpu_we;
        maddr = sel ? spc_addr : cpu_addr;
        mwd = sel ? spc_wdata : cpu_wdata;
        if (mwe) ref_mem[maddr] = mwd;
        else mpend = ref_mem[maddr];
      end
      step();
    end
    cpu_req = 1'b0;
    spc_req = 1'b0;
    repeat (4) step();

    // Reset in the middle of a CPU write: no ack may follow.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h7777;
    step();
    chk1("mid_we", mem_we, 1'b1);
    chk1("mid_busy", busy, 1'b1);
    reset = 1'b0;
    cpu_req = 1'b0;
    step();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_we", mem_we, 1'b0);
    chk1("mid_rst_ack", cpu_ack, 1'b0);
    chk16("mid_rst_addr", mem_addr, 16'h0000);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk1("mid_no_ack", cpu_ack | spc_ack, 1'b0);
      chk1("mid_idle", busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
